axis_dm_cmd_gen: RTL and testbench

- Parametrised AXI DataMover command generator: splits a buffer transfer of total_size bytes at base_addr into DataMover commands.
- Commands are capped at MAX_BURST_LEN and never cross a 4 KB boundary.
- Consumes the DataMover status stream and bounds the number of outstanding commands.
- Supports single-shot or continuous ring capture/playback.
- Sits between the PS-side control registers and one DataMover channel: MM2S or S2MM, chosen by parameter.

---
 rtl/axis_dm_cmd_gen.sv | 195 +++++++++++++++++++
 tb/tb_axis_dm_cmd_gen.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_dm_cmd_gen.sv
// AXI DataMover command generator: slices a buffer into INCR commands capped at MAX_BURST_LEN
// that never cross a 4 KB boundary, and uses returned status to bound the commands in flight.
module axis_dm_cmd_gen #(
    parameter int ADDR_WIDTH      = 32,
    parameter int BTT_WIDTH       = 23,
    parameter int MAX_BURST_LEN   = 512,
    parameter int MAX_OUTSTANDING = 4,
    parameter bit DIR_S2MM        = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  continuous,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [31:0]           total_size,
    output logic [ADDR_WIDTH+39:0] m_axis_cmd_tdata,
    output logic                  m_axis_cmd_tvalid,
    input  logic                  m_axis_cmd_tready,
    input  logic [7:0]            s_axis_sts_tdata,
    input  logic                  s_axis_sts_tvalid,
    output logic                  s_axis_sts_tready,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [15:0]           frame_count,
    output logic [3:0]            outstanding
);

    // Handshakes: a beat transfers on a rising edge where valid and ready are both high; once
    // tvalid is raised, tdata and tvalid hold until that edge. Status is always accepted.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_base;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [31:0]             r_total;
    logic [31:0]             r_remaining;
    logic [3:0]              r_tag;
    logic [3:0]              r_outstanding;
    logic                    r_tvalid;
    logic [ADDR_WIDTH+39:0]  r_tdata;
    logic                    r_err;
    logic                    r_done;
    logic                    r_stop;
    logic [15:0]             r_frame_cnt;
    logic [15:0]             r_eof_mask;

    logic [31:0]             w_to_4k;
    logic [31:0]             w_min_burst;
    logic [31:0]             w_chunk;
    logic [22:0]             w_btt;
    logic                    w_last;
    logic [ADDR_WIDTH+39:0]  w_cmd;
    logic                    w_hs;
    logic                    w_sts_accept;
    logic                    w_sts_stray;
    logic                    w_sts_bad;
    logic [3:0]              w_sts_tag;
    logic                    w_stop;
    logic [15:0]             w_eof_mask_nxt;
    logic                    w_unused;

    assign w_to_4k     = 32'd4096 - {20'd0, r_addr[11:0]};
    assign w_min_burst = (r_remaining < 32'(MAX_BURST_LEN)) ? r_remaining : 32'(MAX_BURST_LEN);
    assign w_chunk     = (w_min_burst < w_to_4k) ? w_min_burst : w_to_4k;
    assign w_btt       = 23'(w_chunk[BTT_WIDTH-1:0]);
    assign w_last      = (w_chunk == r_remaining);
    assign w_cmd       = {4'b0000, r_tag, r_addr, 1'b0, w_last, 6'b000000, 1'b1, w_btt};

    assign w_hs         = r_tvalid & m_axis_cmd_tready;
    assign w_sts_tag    = s_axis_sts_tdata[3:0];
    assign w_sts_bad    = ~s_axis_sts_tdata[7] | (|s_axis_sts_tdata[6:4]);
    assign w_sts_accept = s_axis_sts_tvalid & (r_outstanding != 4'd0);
    assign w_sts_stray  = s_axis_sts_tvalid & (r_outstanding == 4'd0);
    // Anything that must prevent the next command from being presented, including this cycle's events.
    assign w_stop       = r_stop | abort | (w_sts_accept & w_sts_bad);

    // Tags whose command closed a frame; its OKAY status is what counts a completed frame.
    always_comb begin
        w_eof_mask_nxt = r_eof_mask;
        if (w_sts_accept) begin
            w_eof_mask_nxt[w_sts_tag] = 1'b0;
        end
        if (w_hs && w_last) begin
            w_eof_mask_nxt[r_tag] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_base        <= '0;
            r_addr        <= '0;
            r_total       <= '0;
            r_remaining   <= '0;
            r_tag         <= '0;
            r_outstanding <= '0;
            r_tvalid      <= 1'b0;
            r_tdata       <= '0;
            r_err         <= 1'b0;
            r_done        <= 1'b0;
            r_stop        <= 1'b0;
            r_frame_cnt   <= '0;
            r_eof_mask    <= '0;
        end else begin
            r_done     <= 1'b0;
            r_eof_mask <= w_eof_mask_nxt;

            if (w_sts_stray || (w_sts_accept && w_sts_bad)) begin
                r_err <= 1'b1;
            end
            if (w_sts_accept && r_eof_mask[w_sts_tag] && !w_sts_bad) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end

            case ({w_hs, w_sts_accept})
                2'b10:   r_outstanding <= r_outstanding + 4'd1;
                2'b01:   r_outstanding <= r_outstanding - 4'd1;
                default: r_outstanding <= r_outstanding;
            endcase

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_base      <= base_addr;
                        r_addr      <= base_addr;
                        r_total     <= total_size;
                        r_remaining <= total_size;
                        r_tag       <= '0;
                        r_err       <= 1'b0;
                        r_frame_cnt <= '0;
                        r_stop      <= 1'b0;
                        if (total_size == 32'd0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= ST_ISSUE;
                        end
                    end
                end

                ST_ISSUE: begin
                    if (abort || (w_sts_accept && w_sts_bad)) begin
                        r_stop <= 1'b1;
                    end
                    if (w_hs) begin
                        r_tvalid    <= 1'b0;
                        r_addr      <= r_addr + ADDR_WIDTH'(w_chunk);
                        r_remaining <= r_remaining - w_chunk;
                        r_tag       <= r_tag + 4'd1;
                        if (w_last && continuous && !w_stop) begin
                            r_addr      <= r_base;
                            r_remaining <= r_total;
                        end else if (w_last || w_stop) begin
                            r_state <= ST_DRAIN;
                        end
                    end else if (!r_tvalid) begin
                        if (w_stop) begin
                            r_state <= ST_DRAIN;
                        end else if (r_outstanding < 4'(MAX_OUTSTANDING)) begin
                            r_tvalid <= 1'b1;
                            r_tdata  <= w_cmd;
                        end
                    end
                end

                ST_DRAIN: begin
                    if (r_outstanding == 4'd0) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // tvalid is masked by reset so a command disappears in the very cycle reset is raised.
    assign m_axis_cmd_tvalid = r_tvalid & ~reset;
    assign m_axis_cmd_tdata  = r_tdata;
    assign s_axis_sts_tready = 1'b1;
    assign busy              = (r_state != ST_IDLE);
    assign done              = r_done;
    assign err               = r_err;
    assign frame_count       = r_frame_cnt;
    assign outstanding       = r_outstanding;

    assign w_unused = &{1'b0, DIR_S2MM, w_chunk[31:BTT_WIDTH]};

endmodule

// File: tb/tb_axis_dm_cmd_gen.sv
// Bench for axis_dm_cmd_gen: a frame-slicing model predicts every command, a status responder
// returns beats with fixed latency, and directed scenarios pin the literal expectations.
module tb_axis_dm_cmd_gen;

    localparam int AW = 32;
    localparam int DW = AW + 40;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic          continuous;
    logic [AW-1:0] base_addr;
    logic [31:0]   total_size;
    logic [DW-1:0] m_axis_cmd_tdata;
    logic          m_axis_cmd_tvalid;
    logic          m_axis_cmd_tready;
    logic [7:0]    s_axis_sts_tdata = 8'h00;
    logic          s_axis_sts_tvalid = 1'b0;
    logic          s_axis_sts_tready;
    logic          busy;
    logic          done;
    logic          err;
    logic [15:0]   frame_count;
    logic [3:0]    outstanding;

    axis_dm_cmd_gen #(
        .ADDR_WIDTH(AW),
        .BTT_WIDTH(23),
        .MAX_BURST_LEN(512),
        .MAX_OUTSTANDING(2),
        .DIR_S2MM(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .continuous(continuous),
        .base_addr(base_addr),
        .total_size(total_size),
        .m_axis_cmd_tdata(m_axis_cmd_tdata),
        .m_axis_cmd_tvalid(m_axis_cmd_tvalid),
        .m_axis_cmd_tready(m_axis_cmd_tready),
        .s_axis_sts_tdata(s_axis_sts_tdata),
        .s_axis_sts_tvalid(s_axis_sts_tvalid),
        .s_axis_sts_tready(s_axis_sts_tready),
        .busy(busy),
        .done(done),
        .err(err),
        .frame_count(frame_count),
        .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int n_hs = 0;
    int n_done = 0;
    int cyc = 0;
    int model_out = 0;
    int release_cnt = 0;
    bit sts_auto = 1'b1;
    bit sts_err_next = 1'b0;
    bit stall = 1'b0;
    logic [DW-1:0] stall_data;
    logic [3:0]    model_tag;
    logic [DW-1:0] exp_q[$];
    logic [3:0]    sts_tag_q[$];
    int            sts_due_q[$];
    logic [DW-1:0] cmd_log[16];
    logic [DW-1:0] held;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, expv);
        end
    endtask

    // Model: slice [base, base+size) into commands, each min(remaining, 512, bytes to next 4 KB).
    function automatic void push_frame(input logic [31:0] base, input logic [31:0] size);
        logic [31:0] a;
        logic [31:0] rem;
        logic [31:0] ch;
        logic [31:0] to4k;
        a   = base;
        rem = size;
        while (rem > 0) begin
            to4k = 32'd4096 - (a % 32'd4096);
            ch   = rem;
            if (ch > 32'd512) ch = 32'd512;
            if (ch > to4k) ch = to4k;
            exp_q.push_back({4'h0, model_tag, a, 1'b0, (rem == ch), 6'h00, 1'b1, ch[22:0]});
            model_tag = model_tag + 4'd1;
            a   = a + ch;
            rem = rem - ch;
        end
    endfunction

    task automatic do_start(input logic [31:0] b, input logic [31:0] s);
        @(posedge clk);
        #1;
        exp_q.delete();
        n_hs = 0;
        n_done = 0;
        model_tag = 4'd0;
        base_addr = b;
        total_size = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_hs(input int n, input string nm);
        int k;
        k = 0;
        while (n_hs < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk(nm, DW'(n_hs >= n), DW'(1));
    endtask

    task automatic wait_done(input int n, input string nm);
        int k;
        k = 0;
        while (n_done < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk(nm, DW'(n_done >= n), DW'(1));
    endtask

    task automatic wait_valid(input string nm);
        int k;
        k = 0;
        @(negedge clk);
        while (!m_axis_cmd_tvalid && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk(nm, DW'(m_axis_cmd_tvalid), DW'(1));
    endtask

    // Per-cycle checker: command stream against the model, AXIS hold rule, outstanding count.
    always @(negedge clk) begin
        bit dec;
        if (reset) begin
            model_out = 0;
            stall = 1'b0;
        end else begin
            chk("outstanding", DW'(outstanding), DW'(model_out));
            if (stall) begin
                chk("tvalid_hold", DW'(m_axis_cmd_tvalid), DW'(1));
                chk("tdata_hold", m_axis_cmd_tdata, stall_data);
            end
            dec = s_axis_sts_tvalid && (model_out > 0);
            if (m_axis_cmd_tvalid && m_axis_cmd_tready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_cmd got=%h want=none", m_axis_cmd_tdata);
                end else begin
                    chk("cmd", m_axis_cmd_tdata, exp_q.pop_front());
                end
                if (n_hs < 16) cmd_log[n_hs] = m_axis_cmd_tdata;
                n_hs++;
                sts_tag_q.push_back(m_axis_cmd_tdata[67:64]);
                sts_due_q.push_back(cyc + 3);
                model_out++;
            end
            if (dec) model_out--;
            stall = m_axis_cmd_tvalid && !m_axis_cmd_tready;
            stall_data = m_axis_cmd_tdata;
            if (done) n_done++;
        end
    end

    // Status responder: one beat per accepted command, about three cycles later.
    always begin
        @(posedge clk);
        #1;
        cyc++;
        s_axis_sts_tvalid = 1'b0;
        s_axis_sts_tdata = 8'h00;
        if (!reset && sts_tag_q.size() > 0 && sts_due_q[0] <= cyc && (sts_auto || release_cnt > 0)) begin
            s_axis_sts_tdata = {(sts_err_next ? 4'h4 : 4'h8), sts_tag_q.pop_front()};
            void'(sts_due_q.pop_front());
            s_axis_sts_tvalid = 1'b1;
            sts_err_next = 1'b0;
            if (!sts_auto) release_cnt--;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        continuous = 1'b0;
        base_addr = '0;
        total_size = '0;
        m_axis_cmd_tready = 1'b1;
        model_tag = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_tvalid", DW'(m_axis_cmd_tvalid), DW'(0));
        chk("rst_tdata", m_axis_cmd_tdata, DW'(0));
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_done", DW'(done), DW'(0));
        chk("rst_err", DW'(err), DW'(0));
        chk("rst_frames", DW'(frame_count), DW'(0));
        chk("rst_sts_tready", DW'(s_axis_sts_tready), DW'(1));

        // Aligned 2 KB frame: four 512-byte commands, EOF on the last.
        do_start(32'h1000_0000, 32'd2048);
        push_frame(32'h1000_0000, 32'd2048);
        wait_hs(1, "t1_first_cmd");
        chk("t1_busy", DW'(busy), DW'(1));
        wait_done(1, "t1_done");
        repeat (10) @(negedge clk);
        chk("t1_ncmd", DW'(n_hs), DW'(4));
        chk("t1_ndone", DW'(n_done), DW'(1));
        chk("t1_frames", DW'(frame_count), DW'(1));
        chk("t1_cmd0", cmd_log[0], {8'h00, 32'h1000_0000, 32'h0080_0200});
        chk("t1_cmd1", cmd_log[1], {8'h01, 32'h1000_0200, 32'h0080_0200});
        chk("t1_cmd3", cmd_log[3], {8'h03, 32'h1000_0600, 32'h4080_0200});

        // Start just below a 4 KB boundary.
        do_start(32'h0000_0F00, 32'd1024);
        push_frame(32'h0000_0F00, 32'd1024);
        wait_done(1, "t2_done");
        repeat (5) @(negedge clk);
        chk("t2_ncmd", DW'(n_hs), DW'(3));
        chk("t2_cmd0", cmd_log[0], {8'h00, 32'h0000_0F00, 32'h0080_0100});
        chk("t2_cmd1", cmd_log[1], {8'h01, 32'h0000_1000, 32'h0080_0200});
        chk("t2_cmd2", cmd_log[2], {8'h02, 32'h0000_1200, 32'h4080_0100});

        // Status withheld: the outstanding limit of 2 must stall issuing.
        sts_auto = 1'b0;
        do_start(32'h0000_2000, 32'd2048);
        push_frame(32'h0000_2000, 32'd2048);
        repeat (20) @(negedge clk);
        chk("t3_ncmd_stalled", DW'(n_hs), DW'(2));
        chk("t3_tvalid_low", DW'(m_axis_cmd_tvalid), DW'(0));
        chk("t3_outstanding", DW'(outstanding), DW'(2));
        release_cnt = 1;
        wait_hs(3, "t3_third_cmd");
        repeat (10) @(negedge clk);
        chk("t3_ncmd_after_release", DW'(n_hs), DW'(3));
        sts_auto = 1'b1;
        wait_done(1, "t3_done");
        chk("t3_frames", DW'(frame_count), DW'(1));

        // Ring mode: three frames, continuous dropped during the third.
        continuous = 1'b1;
        do_start(32'h3000_0000, 32'd1024);
        push_frame(32'h3000_0000, 32'd1024);
        push_frame(32'h3000_0000, 32'd1024);
        push_frame(32'h3000_0000, 32'd1024);
        wait_hs(5, "t4_fifth_cmd");
        @(posedge clk);
        #1;
        continuous = 1'b0;
        wait_done(1, "t4_done");
        repeat (5) @(negedge clk);
        chk("t4_ncmd", DW'(n_hs), DW'(6));
        chk("t4_frames", DW'(frame_count), DW'(3));
        chk("t4_cmd1", cmd_log[1], {8'h01, 32'h3000_0200, 32'h4080_0200});
        chk("t4_cmd2_wrap", cmd_log[2], {8'h02, 32'h3000_0000, 32'h0080_0200});
        chk("t4_cmd5", cmd_log[5], {8'h05, 32'h3000_0200, 32'h4080_0200});

        // Abort while the first command is stuck on tready.
        m_axis_cmd_tready = 1'b0;
        do_start(32'h4000_0000, 32'd2048);
        push_frame(32'h4000_0000, 32'd2048);
        wait_valid("t5_valid");
        held = m_axis_cmd_tdata;
        chk("t5_held_cmd", held, {8'h00, 32'h4000_0000, 32'h0080_0200});
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_axis_cmd_tready = 1'b1;
        wait_done(1, "t5_done");
        repeat (10) @(negedge clk);
        chk("t5_ncmd", DW'(n_hs), DW'(1));
        chk("t5_frames", DW'(frame_count), DW'(0));
        chk("t5_err", DW'(err), DW'(0));

        // SLVERR on the first status stops issuing and latches err.
        sts_err_next = 1'b1;
        do_start(32'h5000_0000, 32'd2048);
        push_frame(32'h5000_0000, 32'd2048);
        wait_done(1, "t6_done");
        repeat (5) @(negedge clk);
        chk("t6_err", DW'(err), DW'(1));
        chk("t6_issue_stopped", DW'(n_hs < 4), DW'(1));
        chk("t6_frames", DW'(frame_count), DW'(0));
        chk("t6_busy", DW'(busy), DW'(0));

        // Zero-size start: immediate done, no command, clears err.
        do_start(32'h7000_0000, 32'd0);
        chk("t7_done_pulse", DW'(done), DW'(1));
        chk("t7_err_cleared", DW'(err), DW'(0));
        chk("t7_busy", DW'(busy), DW'(0));
        repeat (5) @(negedge clk);
        chk("t7_ncmd", DW'(n_hs), DW'(0));
        chk("t7_ndone", DW'(n_done), DW'(1));

        // Reset with one command outstanding and another being presented.
        sts_auto = 1'b0;
        do_start(32'h6000_0000, 32'd2048);
        push_frame(32'h6000_0000, 32'd2048);
        wait_hs(1, "t8_first_cmd");
        @(posedge clk);
        #1;
        m_axis_cmd_tready = 1'b0;
        wait_valid("t8_valid");
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("t8_tvalid_same_cycle", DW'(m_axis_cmd_tvalid), DW'(0));
        @(posedge clk);
        #1;
        sts_tag_q.delete();
        sts_due_q.delete();
        exp_q.delete();
        @(negedge clk);
        chk("t8_outstanding", DW'(outstanding), DW'(0));
        chk("t8_busy", DW'(busy), DW'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_axis_cmd_tready = 1'b1;
        sts_auto = 1'b1;
        repeat (5) @(negedge clk);
        chk("t8_idle_tvalid", DW'(m_axis_cmd_tvalid), DW'(0));
        chk("t8_idle_frames", DW'(frame_count), DW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
